// File: rtl/button_event_decoder_pkg.sv
// rtl/button_event_decoder_pkg.sv - shared timing defaults and FSM state type for the button event decoder
package button_event_decoder_pkg;

  localparam int unsigned LONG_CYCLES_DEFAULT = 12_500_000;
  localparam int unsigned GAP_CYCLES_DEFAULT  = 6_250_000;
  localparam int unsigned LONG_CYCLES_SIM     = 8;
  localparam int unsigned GAP_CYCLES_SIM      = 6;
  localparam int unsigned CNT_W_DEFAULT       = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESSED   = 3'd1,
    ST_LONG_HELD = 3'd2,
    ST_WAIT_GAP  = 3'd3,
    ST_PRESS2    = 3'd4
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_decoder_edge_detect.sv
// rtl/button_event_decoder_edge_detect.sv - one-register rise/fall detector for an already-synchronous level
module edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_level
);

  logic prev_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= i_level;
    end
  end

  assign o_rise  = i_level & ~prev_q;
  assign o_fall  = ~i_level & prev_q;
  assign o_level = prev_q;

endmodule

// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - classifies debounced presses into short/long/double pulses and counts presses
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEFAULT,
  parameter int unsigned GAP_CYCLES  = GAP_CYCLES_DEFAULT,
  parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clean,
  output logic             o_pressed,
  output logic             o_short,
  output logic             o_long,
  output logic             o_double,
  output logic [CNT_W-1:0] o_press_count
);

  localparam int unsigned TW = $clog2(max_u(LONG_CYCLES, GAP_CYCLES) + 1);
  localparam logic [TW-1:0] LONG_LAST = TW'(LONG_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_MAX = '1;

  logic rise;
  logic fall;
  logic level;

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             double_q, double_d;
  logic [CNT_W-1:0] count_q, count_d;

  edge_detect u_edge (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_level (i_clean),
    .o_rise  (rise),
    .o_fall  (fall),
    .o_level (level)
  );

  // Release beats long-expiry and re-press beats gap-expiry when both land on the same edge.
  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    count_d  = count_q;

    case (state_q)
      ST_IDLE: begin
        if (rise) state_d = ST_PRESSED;
      end
      ST_PRESSED: begin
        if (fall) begin
          state_d = ST_WAIT_GAP;
        end else if (timer_q == LONG_LAST) begin
          state_d = ST_LONG_HELD;
          long_d  = 1'b1;
        end
      end
      ST_LONG_HELD: begin
        if (fall) state_d = ST_IDLE;
      end
      ST_WAIT_GAP: begin
        if (rise) begin
          state_d = ST_PRESS2;
        end else if (timer_q == GAP_LAST) begin
          state_d = ST_IDLE;
          short_d = 1'b1;
        end
      end
      ST_PRESS2: begin
        if (fall) begin
          state_d  = ST_IDLE;
          double_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) begin
      timer_d = '0;
    end else if (timer_q == TIMER_MAX) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + TW'(1);
    end

    if (rise) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      count_q  <= count_d;
    end
  end

  assign o_pressed     = level;
  assign o_short       = short_q;
  assign o_long        = long_q;
  assign o_double      = double_q;
  assign o_press_count = count_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// tb/tb_button_event_decoder.sv - self-checking bench for button_event_decoder at sim-scale timing
module tb_button_event_decoder;
  import button_event_decoder_pkg::*;

  localparam int LONG  = LONG_CYCLES_SIM;
  localparam int GAP   = GAP_CYCLES_SIM;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             clean;
  logic             o_pressed, o_short, o_long, o_double;
  logic [CNT_W-1:0] o_press_count;

  always #5 clk = ~clk;

  button_event_decoder #(
    .LONG_CYCLES (LONG),
    .GAP_CYCLES  (GAP),
    .CNT_W       (CNT_W)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_clean       (clean),
    .o_pressed     (o_pressed),
    .o_short       (o_short),
    .o_long        (o_long),
    .o_double      (o_double),
    .o_press_count (o_press_count)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: press phase plus the cycle stamp at which it was entered.
  // phase 0 idle, 1 first press held, 2 long reached, 3 released awaiting re-press, 4 second press
  int phase = 0;
  int enter_cyc = 0;
  int cyc = 0;
  bit m_prev = 0;
  bit e_short = 0, e_long = 0, e_double = 0, e_pressed = 0;
  int e_count = 0;

  always @(posedge clk) begin
    int nphase;
    bit r, f;
    cyc++;
    if (rst) begin
      phase = 0; m_prev = 0; e_count = 0;
      e_short = 0; e_long = 0; e_double = 0; e_pressed = 0;
    end else begin
      r = clean && !m_prev;
      f = !clean && m_prev;
      m_prev = clean;
      e_pressed = clean;
      e_short = 0; e_long = 0; e_double = 0;
      nphase = phase;
      if (phase == 0 && r) nphase = 1;
      else if (phase == 1 && f) nphase = 3;
      else if (phase == 1 && cyc - enter_cyc == LONG) begin nphase = 2; e_long = 1; end
      else if (phase == 2 && f) nphase = 0;
      else if (phase == 3 && r) nphase = 4;
      else if (phase == 3 && cyc - enter_cyc == GAP) begin nphase = 0; e_short = 1; end
      else if (phase == 4 && f) begin nphase = 0; e_double = 1; end
      if (nphase != phase) enter_cyc = cyc;
      phase = nphase;
      if (r) e_count = (e_count + 1) % (1 << CNT_W);
    end
  end

  int n_short = 0, n_long = 0, n_double = 0;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_pressed", 32'(o_pressed), 0);
      check("rst_short", 32'(o_short), 0);
      check("rst_long", 32'(o_long), 0);
      check("rst_double", 32'(o_double), 0);
      check("rst_count", 32'(o_press_count), 0);
    end else begin
      check("pressed", 32'(o_pressed), 32'(e_pressed));
      check("short", 32'(o_short), 32'(e_short));
      check("long", 32'(o_long), 32'(e_long));
      check("double", 32'(o_double), 32'(e_double));
      check("count", 32'(o_press_count), 32'(e_count));
    end
    if (o_short) n_short++;
    if (o_long) n_long++;
    if (o_double) n_double++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  int s0, l0, d0;

  task automatic do_reset();
    rst = 1'b1;
    clean = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    s0 = n_short; l0 = n_long; d0 = n_double;
  endtask

  task automatic deltas(input string tag, input int ds, input int dl, input int dd, input int cnt);
    check({tag, "_nshort"}, 32'(n_short - s0), 32'(ds));
    check({tag, "_nlong"}, 32'(n_long - l0), 32'(dl));
    check({tag, "_ndouble"}, 32'(n_double - d0), 32'(dd));
    check({tag, "_count"}, 32'(o_press_count), 32'(cnt));
  endtask

  initial begin
    rst = 1'b1;
    clean = 1'b0;
    tick(3);
    check("reset_count", 32'(o_press_count), 0);
    check("reset_pressed", 32'(o_pressed), 0);
    rst = 1'b0;
    tick(2);

    // short press: pulse 6 edges after the fall edge
    do_reset();
    clean = 1'b1; tick(3);
    clean = 1'b0; tick(6);
    check("t1_short_before", 32'(o_short), 0);
    tick(1);
    check("t1_short_at_gap", 32'(o_short), 1);
    tick(1);
    check("t1_short_after", 32'(o_short), 0);
    tick(3);
    deltas("t1", 1, 0, 0, 1);

    // long press: pulse 8 edges after the rise edge, nothing on release
    do_reset();
    clean = 1'b1; tick(8);
    check("t2_long_before", 32'(o_long), 0);
    tick(1);
    check("t2_long_at_hold", 32'(o_long), 1);
    tick(1);
    check("t2_long_after", 32'(o_long), 0);
    tick(10);
    clean = 1'b0; tick(15);
    deltas("t2", 0, 1, 0, 1);

    // double click
    do_reset();
    clean = 1'b1; tick(2);
    clean = 1'b0; tick(3);
    clean = 1'b1; tick(2);
    clean = 1'b0; tick(1);
    check("t3_double_on_fall", 32'(o_double), 1);
    tick(1);
    check("t3_double_after", 32'(o_double), 0);
    tick(10);
    deltas("t3", 0, 0, 1, 2);

    // release lands on the long-expiry edge
    do_reset();
    clean = 1'b1; tick(8);
    clean = 1'b0; tick(15);
    deltas("t4a", 1, 0, 0, 1);

    // re-press lands on the gap-expiry edge
    do_reset();
    clean = 1'b1; tick(3);
    clean = 1'b0; tick(6);
    clean = 1'b1; tick(2);
    clean = 1'b0; tick(1);
    check("t4b_double", 32'(o_double), 1);
    tick(10);
    deltas("t4b", 0, 0, 1, 2);

    // counter wrap over 256 spaced short presses
    do_reset();
    for (int i = 0; i < 256; i++) begin
      clean = 1'b1; tick(2);
      clean = 1'b0; tick(9);
      if (i == 254) check("t5_count_255", 32'(o_press_count), 255);
    end
    tick(5);
    deltas("t5", 256, 0, 0, 0);

    // reset mid-press clears asynchronously; release under reset raises nothing
    do_reset();
    clean = 1'b1; tick(4);
    check("t6_pressed_pre", 32'(o_pressed), 1);
    rst = 1'b1;
    #1;
    check("t6_async_pressed", 32'(o_pressed), 0);
    check("t6_async_count", 32'(o_press_count), 0);
    clean = 1'b0; tick(2);
    rst = 1'b0; tick(15);
    deltas("t6", 0, 0, 0, 0);

    // button held through reset release counts as a fresh press
    rst = 1'b1; clean = 1'b1; tick(2);
    s0 = n_short; l0 = n_long; d0 = n_double;
    rst = 1'b0; tick(1);
    check("t7_count", 32'(o_press_count), 1);
    clean = 1'b0; tick(15);
    deltas("t7", 1, 0, 0, 1);

    // randomized level trains with occasional resets, checked by the model every cycle
    do_reset();
    for (int i = 0; i < 400; i++) begin
      clean = ~clean;
      tick($urandom_range(1, 12));
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        tick($urandom_range(1, 2));
        rst = 1'b0;
      end
    end
    clean = 1'b0;
    tick(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
